// File: rtl/dibit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dibit_pkg
//  Description : Shared types and constants for the serial-to-dibit packer.
//                state_t  - packer FSM states (no held bit / one held bit)
//                PAD_BIT  - filler bit used to complete a flushed half-symbol
//                SYM_W    - symbol width in bits
//                SYM_IDLE - value presented on sym_data when no symbol is valid
//  Revision    : 1.0 - initial release
// ============================================================================
package dibit_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HALF = 1'b1
    } state_t;

    localparam logic           PAD_BIT  = 1'b0;
    localparam int             SYM_W    = 2;
    localparam logic [SYM_W-1:0] SYM_IDLE = 2'b00;

endpackage
`default_nettype wire

// File: rtl/dibit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dibit_fifo
//  Description : Small synchronous FIFO for 2-bit symbols. Read/write pointers
//                carry one extra MSB so full and empty are distinguishable
//                without a separate occupancy counter.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                push, push_data - write strobe and symbol
//                pop             - read strobe (ignored when empty)
//                full, empty     - occupancy flags (registered-state only)
//                head            - oldest stored symbol
//  Revision    : 1.0 - initial release
// ============================================================================
module dibit_fifo
    import dibit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [SYM_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is legal when accompanied by a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: contents are only observed through head
    // while the pointers say the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dibit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : dibit_packer
//  Description : Packs a valid/ready 1-bit stream into 2-bit symbols (first
//                received bit in bit[1]) and buffers them in a FIFO. A flush
//                pulse pads a held half-symbol with PAD_BIT and emits it.
//  Ports       : clk, rst_n                   - clock, sync active-low reset
//                bit_valid, bit_data, bit_ready - input bit handshake
//                flush                        - pad/emit pending half-symbol
//                sym_valid, sym_data, sym_ready - output symbol handshake
//                sym_count                    - symbols pushed (wrapping)
//                flush_busy                   - latched flush not yet serviced
//  Revision    : 1.0 - initial release
// ============================================================================
module dibit_packer
    import dibit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    input  logic             flush,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_data,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] sym_count,
    output logic             flush_busy
);

    state_t           state;
    state_t           state_d;
    logic             hold_q;
    logic             hold_d;
    logic             flush_pend;
    logic             pend_d;
    logic             push;
    logic [SYM_W-1:0] push_data;
    logic             pop;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SYM_W-1:0] fifo_head;

    // Registered-state only: no combinational path from sym_ready.
    assign bit_ready  = !flush_pend && ((state == S_IDLE) || !fifo_full);
    assign accept     = bit_valid && bit_ready;
    assign sym_valid  = !fifo_empty;
    assign sym_data   = fifo_empty ? SYM_IDLE : fifo_head;
    assign pop        = sym_valid && sym_ready;
    assign flush_busy = flush_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hold_q     <= 1'b0;
            flush_pend <= 1'b0;
            sym_count  <= '0;
        end else begin
            state      <= state_d;
            hold_q     <= hold_d;
            flush_pend <= pend_d;
            if (push) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state;
        hold_d    = hold_q;
        pend_d    = flush_pend;
        push      = 1'b0;
        push_data = SYM_IDLE;
        case (state)
            S_IDLE: begin
                // A flush here has nothing to pad and is dropped.
                if (accept) begin
                    hold_d  = bit_data;
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                if (flush_pend) begin
                    // bit_ready is low while pending, so accept cannot occur.
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_data = {hold_q, PAD_BIT};
                        state_d   = S_IDLE;
                        pend_d    = 1'b0;
                    end
                end else if (accept) begin
                    // A real bit completes the symbol; a coincident flush is moot.
                    push      = 1'b1;
                    push_data = {hold_q, bit_data};
                    state_d   = S_IDLE;
                end else if (flush) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                hold_d    = 1'b0;
                pend_d    = 1'b0;
                push      = 1'b0;
                push_data = SYM_IDLE;
            end
        endcase
    end

    dibit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
`default_nettype wire

// File: doc/dibit_packer.md
# dibit_packer

Serial-to-dibit packer: accepts a 1-bit stream under a valid/ready handshake, assembles consecutive bit pairs into 2-bit symbols, and buffers them in a small FIFO. Symbols leave on a valid/ready output port. It is the transmit-side counterpart of the 2-bit symbol decoders in this design: it produces the 2-bit symbols those decoders consume. A flush request pads a dangling half-symbol so that no received bit is stranded.

## Interface
- DEPTH, 2, output FIFO depth in symbols; power of two, minimum 2
- CNT_W, 8, width of the symbol counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- bit_valid  input  1  upstream bit present
- bit_data  input  1  upstream bit value
- bit_ready  output  1  packer accepts a bit this cycle
- flush  input  1  single-cycle request to pad and emit a pending half-symbol
- sym_valid  output  1  FIFO head valid
- sym_data  output  2  FIFO head symbol; bit[1] is the first-received bit
- sym_ready  input  1  downstream accepts the head symbol
- sym_count  output  CNT_W  symbols pushed into the FIFO since reset; wraps modulo 2^CNT_W
- flush_busy  output  1  a latched flush is waiting to be serviced

## Operation
- Bit accept: bit_valid && bit_ready. Symbol pop: sym_valid && sym_ready.
- FSM states:
  - S_IDLE: no held bit.
  - S_HALF: one held bit in hold_q.
- S_IDLE + accept: hold_q <= bit_data, go to S_HALF. Nothing is pushed.
- S_HALF + accept: push {hold_q, bit_data}, increment sym_count, go to S_IDLE.
- bit_ready = !flush_pend && (state==S_IDLE || !fifo_full). It depends only on registered state, with no combinational path from sym_ready.
- flush pulse:
  - In S_IDLE: no-op.
  - In S_HALF: sets flush_pend. flush_busy = flush_pend.
- flush_pend service: when set and the FIFO is not full, push {hold_q, 1'b0}, increment sym_count, go to S_IDLE, and clear flush_pend.
  - flush_pend set and FIFO not full in the same cycle as the flush pulse: service takes effect in the following cycle.
- Simultaneous bit accept and flush pulse in S_HALF: the bit completes the symbol and the flush is discarded. flush_pend stays clear.
- While flush_pend is set, bit_ready is held low, so no bit can overtake the padded symbol.
- FIFO: first-in first-out, DEPTH entries. Push and pop in the same cycle are both honoured, including when full (pop frees the slot) and when empty (push only; pop is impossible because sym_valid is low).
- sym_data reads 2'b00 whenever sym_valid is low.
- Every case statement enumerates all state and encoding values and has a default arm that drives the reset values. No latches.

## Timing
- Reset, applied on any edge where rst_n is low, wipes any in-progress operation. All inputs are ignored during reset.

| Signal | Reset value |
|---|---|
| state | S_IDLE |
| hold_q | 0 |
| flush_pend | 0 |
| FIFO | empty |
| sym_valid | 0 |
| sym_data | 2'b00 |
| sym_count | 0 |
| flush_busy | 0 |
| bit_ready | 1 in the first cycle after reset release (combinational from reset state) |

- Latency: a symbol completed by a bit accept at edge N is visible on sym_valid/sym_data after edge N, provided the FIFO was empty. Back-to-back bits therefore give one symbol every 2 cycles.
- Flush latency: flush at edge N with a non-full FIFO puts the padded symbol on the output after edge N+1.
- Throughput: with sym_ready held high, the FIFO never fills and bit_ready stays 1 (apart from flush windows).
- sym_count updates on the push edge and wraps from 2^CNT_W-1 to 0 silently.

## Structure
- Package dibit_pkg holds:
  - state enum (S_IDLE, S_HALF)
  - PAD_BIT = 1'b0
  - SYM_W = 2
  - SYM_IDLE = 2'b00
- Sub-module dibit_fifo:
  - Parameterised DEPTH, width SYM_W.
  - Ports: push, push_data, pop, full, empty, head.
  - Wrap-around pointers with an extra MSB for full/empty detection.
- Top level: FSM, hold_q, flush_pend, sym_count, bit_ready logic.

## Test plan
- Stream bits 1,0,1,1 with sym_ready=1 -> symbols 2'b10 then 2'b11, one cycle after each second bit; sym_count=2.
- Stream bit 1, then flush -> sym_data=2'b10 two cycles after the flush; flush_busy high for one cycle; state S_IDLE.
- sym_ready=0, stream 2*DEPTH+1 bits -> FIFO full after DEPTH symbols; bit_ready drops with one bit held; raising sym_ready drains the symbols in order, then accepts the remaining bit.
- Flush in S_HALF while the FIFO is full -> flush_busy stays high and bit_ready=0 until one pop, then the padded symbol is pushed; ordering is preserved.
- Bit accept and flush pulse in the same cycle in S_HALF -> one symbol carrying the real bit, no padded symbol, flush_busy=0.
- Assert rst_n=0 mid-stream, with a half-symbol held and the FIFO non-empty -> next cycle sym_valid=0, sym_count=0, bit_ready=1; the next two bits form a fresh symbol.
